// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory with a latency-modelling FSM.
// Holds a word-addressed RAM and stalls the pipeline for LATENCY cycles per
// access, followed by a one-cycle DONE pulse. It also produces the
// write-back candidate value (load data or ALU result).
// Optional macro MEM_ALIGN_CHECK_EN: when defined, a misaligned access is
// rejected after one stall cycle and flagged on align_err.
module mem_access_unit #(
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 3,
  parameter int BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  output logic        stall,
  output logic        done,
  output logic [31:0] read_data,
  output logic [31:0] result_out,
  output logic        align_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          is_load;
  logic          misalign;
  logic          commit;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          unused_off;

  assign req     = mem_r_en | mem_w_en;
  // A simultaneous read and write request behaves as a store.
  assign is_load = mem_r_en & ~mem_w_en;

  // Word index relative to BASE_ADDR; upper bits drop so addresses wrap.
  assign off        = alu_result - 32'(BASE_ADDR);
  assign idx        = off[AW+1:2];
  assign unused_off = ^{off[31:AW+2], off[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // The access commits on the edge that ends its last stall cycle.
  assign commit = req & ~misalign &
                  (((state == IDLE) && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == LAST)));

  assign stall      = req & (state != DONE);
  assign result_out = mem_r_en ? read_data : alu_result;

  // RAM write port; reset suppresses any in-flight store.
  always_ff @(posedge clk) begin
    if (!rst && commit && mem_w_en)
      mem[idx] <= val_rm;
  end

  // Latency FSM with registered done/align_err/read_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      done      <= 1'b0;
      align_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      align_err <= 1'b0;
      if (commit && is_load)
        read_data <= mem[idx];
      case (state)
        IDLE: begin
          if (req) begin
            if (misalign) begin
              state     <= DONE;
              done      <= 1'b1;
              align_err <= 1'b1;
              read_data <= '0;
            end else if (LATENCY == 1) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cnt   <= CW'(1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            // Request vanished mid-access: abandon it without side effects.
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random
// loads/stores/idle cycles, all compared against a transaction-level model.
module tb_mem_access_unit;

  localparam int DEPTH     = 64;
  localparam int LATENCY   = 3;
  localparam int BASE_ADDR = 1024;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, val_rm;
  logic        mem_r_en, mem_w_en;
  logic        stall, done, align_err;
  logic [31:0] read_data, result_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory image and last loaded value.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] rd_m;

  mem_access_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .val_rm(val_rm),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .stall(stall), .done(done),
    .read_data(read_data), .result_out(result_out), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete memory transaction, checked against the model.
  task automatic access(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] data);
    int          stalls;
    int          cyc;
    int          idx;
    bit          mis;
    logic [31:0] rd_exp;
    mis = ALIGN_EN && (addr[1:0] != 2'b00);
    idx = int'(((addr - 32'(BASE_ADDR)) >> 2) % DEPTH);
    if (mis)         rd_exp = 32'h0;
    else if (r && !w) rd_exp = mem_m[idx];
    else             rd_exp = rd_m;
    if (w && !mis) mem_m[idx] = data;
    rd_m = rd_exp;

    @(negedge clk);
    mem_r_en = r; mem_w_en = w; alu_result = addr; val_rm = data;
    #1;
    stalls = 0;
    cyc    = 0;
    while (done !== 1'b1 && cyc < 32) begin
      if (stall === 1'b1) stalls++;
      cyc++;
      @(negedge clk); #1;
    end
    chk("timeout",    32'(cyc < 32), 32'd1);
    chk("stall_cnt",  32'(stalls), mis ? 32'd1 : 32'(LATENCY));
    chk("done",       32'(done), 32'd1);
    chk("stall_done", 32'(stall), 32'd0);
    chk("read_data",  read_data, rd_exp);
    chk("result_out", result_out, r ? rd_exp : addr);
    chk("align_err",  32'(align_err), 32'(mis));
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    @(negedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  // Non-memory cycle: pure pass-through, no stall.
  task automatic idle_check(input logic [31:0] addr);
    @(negedge clk);
    mem_r_en = 1'b0; mem_w_en = 1'b0; alu_result = addr;
    #1;
    chk("idle_stall",  32'(stall), 32'd0);
    chk("idle_done",   32'(done), 32'd0);
    chk("idle_result", result_out, addr);
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_result = '0; val_rm = '0;
    rd_m = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_align", 32'(align_err), 32'd0);
    rst = 1'b0;

    // Store then load back.
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("tp_load", read_data, 32'hDEADBEEF);

    // Address 1280 wraps onto word 0.
    access(1'b0, 1'b1, 32'd1280, 32'h00000011);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("tp_wrap", read_data, 32'h00000011);

    // Reset during a store discards it.
    access(1'b0, 1'b1, 32'd1028, 32'h0000AAAA);
    @(negedge clk);
    mem_w_en = 1'b1; alu_result = 32'd1028; val_rm = 32'h55;
    #1; chk("rmid_stall1", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("rmid_stall2", 32'(stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_w_en = 1'b0;
    #1;
    chk("rmid_stall_after", 32'(stall), 32'd0);
    chk("rmid_done_after",  32'(done), 32'd0);
    chk("rmid_rdata_rst",   read_data, 32'd0);
    rd_m = '0;
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("tp_rst_keep", read_data, 32'h0000AAAA);

    // Request dropped mid-access: no write, read_data untouched.
    @(negedge clk);
    mem_w_en = 1'b1; alu_result = 32'd1028; val_rm = 32'h1234_5678;
    @(negedge clk);
    mem_w_en = 1'b0;
    #1; chk("abort_stall", 32'(stall), 32'd0);
    repeat (LATENCY + 1) @(negedge clk);
    #1;
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_rdata", read_data, 32'h0000AAAA);
    access(1'b1, 1'b0, 32'd1028, 32'h0);

    // Non-memory instruction.
    idle_check(32'h1234);

`ifdef MEM_ALIGN_CHECK_EN
    access(1'b0, 1'b1, 32'd1026, 32'h99);
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("tp_align_keep", read_data, 32'h00000011);
`endif

    // Fill the whole RAM so every random load has a known value.
    for (int i = 0; i < DEPTH; i++)
      access(1'b0, 1'b1, 32'(BASE_ADDR + 4 * i), $urandom);

    // Random mix of loads, stores, both-high and idle cycles.
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 3));
      a  = 32'(BASE_ADDR) + ($urandom_range(0, 2 * DEPTH - 1) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case (op)
        0:       idle_check($urandom);
        1:       access(1'b1, 1'b0, a, 32'h0);
        2:       access(1'b0, 1'b1, a, $urandom);
        default: access(1'b1, 1'b1, a, $urandom);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle data-memory access block for the MEM stage of the 5-stage ARM pipeline. Sits between the EXE pipeline register and the MEM pipeline register.
- Holds a word-addressed data RAM and runs a latency-modelling FSM. While an access is in flight it raises a stall that feeds the pipeline freeze.
- Produces the write-back candidate value: loaded data for reads, ALU result otherwise.

Parameters:
- DEPTH, 64, number of 32-bit data words (power of 2, >=2).
- LATENCY, 3, stall cycles per memory access (>=1).
- BASE_ADDR, 1024, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_result  input  32  byte address for loads/stores; pass-through value otherwise.
- val_rm  input  32  store data.
- mem_r_en  input  1  load request.
- mem_w_en  input  1  store request.
- stall  output  1  access in progress; upstream must hold its inputs stable.
- done  output  1  one-cycle pulse in the cycle the access completes.
- read_data  output  32  registered load data.
- result_out  output  32  mem_r_en ? read_data : alu_result.
- align_err  output  1  misaligned access flag (see Optional Feature).

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is synchronous, active-high.
- Reset values: state=IDLE, cnt=0, read_data=0, done=0, align_err=0. stall is combinational and is 0 after reset because state=IDLE and no request is implied by reset. RAM contents are not cleared.
- Request: req = mem_r_en | mem_w_en. If both are high the access is treated as a store, and read_data is unchanged.
- Addressing: idx = ((alu_result - BASE_ADDR) >> 2), truncated to log2(DEPTH) bits. Out-of-range addresses wrap modulo DEPTH.
- Stall: stall = req & (state != DONE).
- FSM states:
  - IDLE, no req: stay in IDLE.
  - IDLE, req, LATENCY==1: commit the access at this edge, go to DONE.
  - IDLE, req, LATENCY>1: cnt<=1, go to WAIT.
  - WAIT, cnt < LATENCY-1: cnt<=cnt+1.
  - WAIT, cnt == LATENCY-1: commit the access at this edge, go to DONE.
  - DONE: done=1, stall=0, read_data valid. Go to IDLE at the next edge.
- Commit: a store writes val_rm to RAM[idx]; a load captures RAM[idx] into read_data. Both happen on the same edge.
- Latency: exactly LATENCY stall cycles, then 1 DONE cycle. Back-to-back accesses are separated by the DONE cycle; the next request is seen in IDLE.
- Request dropped in WAIT (protocol violation): abort, go to IDLE, no RAM write, read_data unchanged.
- Reset mid-operation: go to IDLE immediately. An uncommitted store is discarded, and RAM keeps its prior value.
- Non-memory instructions: stall=0, done=0, result_out=alu_result, in the same cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - If req and alu_result[1:0]!=0, the access goes IDLE->DONE after 1 stall cycle regardless of LATENCY.
  - No RAM write; read_data<=0.
  - align_err=1 during that DONE cycle only.
- Undefined: alu_result[1:0] ignored; align_err tied 0.

Test Plan (DEPTH=64, LATENCY=3, BASE_ADDR=1024):
1. Assert rst for 2 cycles, enables 0 -> stall=0, done=0, read_data=0, align_err=0.
2. Store 0xDEADBEEF to 1024, then load 1024:
   - store -> stall=1 for 3 cycles, done pulse on cycle 4;
   - load -> stall=1 for 3 cycles, then done=1 with read_data=result_out=0xDEADBEEF.
3. Store 0x00000011 to 1280 (idx 64 wraps to 0), then load 1024 -> read_data=0x00000011.
4. Store 0xAAAA to 1028; then start a store of 0x55 to 1028 and assert rst in its 2nd stall cycle -> stall=0 next cycle; a later load of 1028 returns 0xAAAA.
5. alu_result=0x1234, mem_r_en=mem_w_en=0 -> stall=0, done=0, result_out=0x1234 in the same cycle.
6. With MEM_ALIGN_CHECK_EN defined: store 0x99 to 1026 -> 1 stall cycle, then done=1 with align_err=1; a load of 1024 returns its prior contents.
